// File: rtl/regfile_pkg.sv
// Shared types and defaults for the register file with scoreboard.
// Latency: n/a (types, constants and pure index-qualification helpers).
// Backpressure: n/a.
package regfile_pkg;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    SWEEP = 1'b1
  } state_t;

  localparam int DEF_WIDTH = 32;
  localparam int DEF_NREG  = 32;

  // Index addresses a physical register (reads of index 0 return the hardwired zero).
  function automatic logic idx_in_range(input int idx, input int nreg);
    return (idx < nreg);
  endfunction

  // Index may be written or issued: register 0 and out-of-range indices are dropped.
  function automatic logic idx_writable(input int idx, input int nreg);
    return (idx > 0) && (idx < nreg);
  endfunction

endpackage

// File: rtl/regfile_scoreboard.sv
// Busy-bit scoreboard: issue sets, write clears, sweep clears one entry per cycle.
// Latency: busy reads combinational; updates visible after the next CLK edge.
// Backpressure: none; strobes arrive pre-qualified (IDLE, valid nonzero index). Option: REGFILE_BYPASS_EN.
module regfile_scoreboard
  import regfile_pkg::*;
#(
  parameter int NREG = DEF_NREG,
  parameter int AW   = $clog2(NREG)
) (
  input  logic          CLK,
  input  logic          RESET_N,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_idx,
  input  logic          iss_en,
  input  logic [AW-1:0] iss_idx,
  input  logic          sweep_en,
  input  logic [AW-1:0] sweep_idx,
  input  logic [AW-1:0] rd_idx1,
  input  logic [AW-1:0] rd_idx2,
  output logic          rd_busy1,
  output logic          rd_busy2
);

  logic [NREG-1:0] busy_q;

  // Per-entry update; issue is applied after write so a same-cycle issue leaves the entry busy.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      busy_q <= '0;
    end else begin
      for (int i = 1; i < NREG; i++) begin
        if (sweep_en && (sweep_idx == AW'(i))) begin
          busy_q[i] <= 1'b0;
        end else if (iss_en && (iss_idx == AW'(i))) begin
          busy_q[i] <= 1'b1;
        end else if (wr_en && (wr_idx == AW'(i))) begin
          busy_q[i] <= 1'b0;
        end
      end
    end
  end

  // Busy read ports; entry 0 is never set so it reads 0 without special-casing.
  always_comb begin
    rd_busy1 = idx_in_range(int'(rd_idx1), NREG) ? busy_q[rd_idx1] : 1'b0;
    rd_busy2 = idx_in_range(int'(rd_idx2), NREG) ? busy_q[rd_idx2] : 1'b0;
`ifdef REGFILE_BYPASS_EN
    // A read hitting this cycle's write sees the post-edge busy value.
    if (wr_en && (rd_idx1 == wr_idx)) rd_busy1 = iss_en && (iss_idx == wr_idx);
    if (wr_en && (rd_idx2 == wr_idx)) rd_busy2 = iss_en && (iss_idx == wr_idx);
`endif
  end

endmodule

// File: rtl/regfile_sb.sv
// Register file (reg 0 hardwired zero) with busy scoreboard and a bulk-clear sweep FSM.
// Latency: reads combinational; writes/issues land on the next edge; bulk clear takes NREG-1 cycles.
// Backpressure: none; writes/issues/clear requests are silently dropped while clear_busy. Option: REGFILE_BYPASS_EN.
module regfile_sb
  import regfile_pkg::*;
#(
  parameter  int WIDTH = DEF_WIDTH,
  parameter  int NREG  = DEF_NREG,
  localparam int AW    = $clog2(NREG)
) (
  input  logic             CLK,
  input  logic             RESET_N,
  input  logic             RegWrite,
  input  logic [AW-1:0]    w_reg,
  input  logic [WIDTH-1:0] w_data,
  input  logic [AW-1:0]    RegRead_1,
  input  logic [AW-1:0]    RegRead_2,
  output logic [WIDTH-1:0] r_data1,
  output logic [WIDTH-1:0] r_data2,
  output logic             r_busy1,
  output logic             r_busy2,
  input  logic             issue_valid,
  input  logic [AW-1:0]    issue_reg,
  input  logic             clear_req,
  output logic             clear_busy
);

  state_t           state;
  logic [AW-1:0]    sweep_idx;
  logic [WIDTH-1:0] mem [NREG];
  logic             we_q;
  logic             iss_q;
  logic             sweep_en;

  // Qualified strobes; RESET_N gating keeps bypassed read outputs at zero while in reset.
  assign we_q     = RESET_N && (state == IDLE) && RegWrite && idx_writable(int'(w_reg), NREG);
  assign iss_q    = RESET_N && (state == IDLE) && issue_valid && idx_writable(int'(issue_reg), NREG);
  assign sweep_en = (state == SWEEP);

  // Clear FSM: IDLE waits for clear_req, SWEEP walks indices 1..NREG-1 one per cycle.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state      <= IDLE;
      sweep_idx  <= AW'(1);
      clear_busy <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (clear_req) begin
            state      <= SWEEP;
            sweep_idx  <= AW'(1);
            clear_busy <= 1'b1;
          end
        end
        SWEEP: begin
          if (sweep_idx == AW'(NREG - 1)) begin
            state      <= IDLE;
            sweep_idx  <= AW'(1);
            clear_busy <= 1'b0;
          end else begin
            sweep_idx <= sweep_idx + 1'b1;
          end
        end
        default: begin
          state      <= IDLE;
          sweep_idx  <= AW'(1);
          clear_busy <= 1'b0;
        end
      endcase
    end
  end

  // Data array; entry 0 is only ever reset, so it stays zero.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      for (int i = 0; i < NREG; i++) mem[i] <= '0;
    end else begin
      for (int i = 1; i < NREG; i++) begin
        if (sweep_en && (sweep_idx == AW'(i))) begin
          mem[i] <= '0;
        end else if (we_q && (w_reg == AW'(i))) begin
          mem[i] <= w_data;
        end
      end
    end
  end

  // Combinational data reads; out-of-range indices return zero.
  always_comb begin
    r_data1 = idx_in_range(int'(RegRead_1), NREG) ? mem[RegRead_1] : '0;
    r_data2 = idx_in_range(int'(RegRead_2), NREG) ? mem[RegRead_2] : '0;
`ifdef REGFILE_BYPASS_EN
    if (we_q && (RegRead_1 == w_reg)) r_data1 = w_data;
    if (we_q && (RegRead_2 == w_reg)) r_data2 = w_data;
`endif
  end

  regfile_scoreboard #(
    .NREG (NREG),
    .AW   (AW)
  ) u_scoreboard (
    .CLK       (CLK),
    .RESET_N   (RESET_N),
    .wr_en     (we_q),
    .wr_idx    (w_reg),
    .iss_en    (iss_q),
    .iss_idx   (issue_reg),
    .sweep_en  (sweep_en),
    .sweep_idx (sweep_idx),
    .rd_idx1   (RegRead_1),
    .rd_idx2   (RegRead_2),
    .rd_busy1  (r_busy1),
    .rd_busy2  (r_busy2)
  );

endmodule
